alu_exec_unit: RTL

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two 32-bit operands, and returns a registered result. Single-cycle ops complete in one cycle. Shifts and the optional multiply run iteratively under an FSM with valid/ready handshakes on both sides. It sits between operand fetch/decode and writeback, and is the receiving end of the ALU control interface.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_iter_core.sv | 81 ++++++++
 rtl/alu_exec_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code enum, FSM states and datapath widths.
// The iterative multiply is gated by ALU_MUL_EN in the units that import this package.
package alu_pkg;
  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;
  localparam int CNT_W   = SHAMT_W + 1;  // must be able to hold XLEN for the multiply

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_NOR = 4'b1100,
    ALU_MUL = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_e;
endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: one-bit-per-cycle shifter and (ALU_MUL_EN) shift-add multiplier.
// done pulses on the final iteration, with res carrying that iteration's value.
module alu_iter_core
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  alu_ctrl_e       op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);
  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  data;
  logic [XLEN-1:0]  step;
  alu_ctrl_e        op_q;
`ifdef ALU_MUL_EN
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
`else
  logic             unused_b;
  assign unused_b = ^b[XLEN-1:SHAMT_W];
`endif

  always_comb begin
    step = data;
    case (op_q)
      ALU_SLL: step = data << 1;
      ALU_SRL: step = data >> 1;
      ALU_SRA: step = {data[XLEN-1], data[XLEN-1:1]};
`ifdef ALU_MUL_EN
      ALU_MUL: step = data + (mplier[0] ? mcand : '0);
`endif
      default: step = data;
    endcase
  end

  assign done = busy && (cnt == CNT_W'(1));
  assign res  = step;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      data <= '0;
      op_q <= ALU_AND;
`ifdef ALU_MUL_EN
      mcand  <= '0;
      mplier <= '0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      op_q <= op;
`ifdef ALU_MUL_EN
      mcand  <= a;
      mplier <= b;
      if (op == ALU_MUL) begin
        data <= '0;
        cnt  <= CNT_W'(XLEN);
      end else begin
        data <= a;
        cnt  <= {1'b0, b[SHAMT_W-1:0]};
      end
`else
      data <= a;
      cnt  <= {1'b0, b[SHAMT_W-1:0]};
`endif
    end else if (busy) begin
      data <= step;
      cnt  <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
`ifdef ALU_MUL_EN
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
`endif
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops resolved at acceptance, shifts/multiply via alu_iter_core.
// Optional multiply enabled by defining ALU_MUL_EN; otherwise code 1111 reports illegal.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      Control_in,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  state_e          state, state_nx;
  alu_ctrl_e       code;
  logic            accept, legal, iter, core_start, core_done;
  logic [XLEN-1:0] imm_res, core_res;

  assign code      = alu_ctrl_e'(Control_in);
  assign out_valid = (state == DONE);
  assign in_ready  = (state == IDLE) && !out_valid;
  assign accept    = in_valid && in_ready;

  // Results that are known at acceptance; iter flags work for the core.
  always_comb begin
    imm_res = '0;
    legal   = 1'b1;
    iter    = 1'b0;
    case (code)
      ALU_AND: imm_res = op_a & op_b;
      ALU_OR:  imm_res = op_a | op_b;
      ALU_ADD: imm_res = op_a + op_b;
      ALU_XOR: imm_res = op_a ^ op_b;
      ALU_SUB: imm_res = op_a - op_b;
      ALU_SLT: imm_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_NOR: imm_res = ~(op_a | op_b);
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        imm_res = op_a;
        iter    = (op_b[SHAMT_W-1:0] != '0);
      end
`ifdef ALU_MUL_EN
      ALU_MUL: iter = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    core_start = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (iter) begin
          core_start = 1'b1;
`ifdef ALU_MUL_EN
          state_nx = (code == ALU_MUL) ? MUL : SHIFT;
`else
          state_nx = SHIFT;
`endif
        end else begin
          state_nx = DONE;
        end
      end
      SHIFT: if (core_done) state_nx = DONE;
`ifdef ALU_MUL_EN
      MUL:   if (core_done) state_nx = DONE;
`endif
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else if (accept && !iter) begin
      result  <= legal ? imm_res : '0;
      zero    <= !legal || (imm_res == '0);
      illegal <= !legal;
    end else if (core_done) begin
      result  <= core_res;
      zero    <= (core_res == '0);
      illegal <= 1'b0;
    end
  end

  alu_iter_core u_iter (
    .clk   (clk),
    .reset (reset),
    .start (core_start),
    .op    (code),
    .a     (op_a),
    .b     (op_b),
    .done  (core_done),
    .res   (core_res)
  );
endmodule
